// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter: redirect modes,
// default vectors and the sequential increment.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_JUMP = 2'b01,
        PC_CALL = 2'b10,
        PC_RET  = 2'b11
    } pc_mode_t;

    localparam logic [31:0] PC_RESET_VECTOR_DEFAULT = 32'h1A00_0000;
    localparam logic [31:0] PC_TRAP_VECTOR_DEFAULT  = 32'h1A00_0080;
    localparam int          PC_INCR                 = 4;

    // Instruction addresses must be word aligned.
    function automatic logic pc_is_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/pc_if.sv
// Bundle between the decode/trap logic (master) and the PC unit (slave).
interface pc_if #(
    parameter int XLEN = 32
);
    logic            ENABLE;
    logic [1:0]      MODE;
    logic [XLEN-1:0] D;
    logic            TRAP;
    logic            TRAP_RET;
    logic [XLEN-1:0] PC_OUT;
    logic [XLEN-1:0] EPC_OUT;
    logic            FAULT;
    logic            RAS_EMPTY;
    logic            RAS_FULL;

    modport master (
        output ENABLE, MODE, D, TRAP, TRAP_RET,
        input  PC_OUT, EPC_OUT, FAULT, RAS_EMPTY, RAS_FULL
    );

    modport slave (
        input  ENABLE, MODE, D, TRAP, TRAP_RET,
        output PC_OUT, EPC_OUT, FAULT, RAS_EMPTY, RAS_FULL
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full silently overwrites the
// oldest entry, and the count saturates at DEPTH.
module pc_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RES,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top_data,
    output logic            empty,
    output logic            full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [PW-1:0]   ptr_reg, ptr_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [XLEN-1:0] entry_reg [DEPTH];

    always_comb begin
        ptr_next   = ptr_reg;
        count_next = count_reg;
        if (push) begin
            ptr_next = ptr_reg + PW'(1);
            if (count_reg != CW'(DEPTH))
                count_next = count_reg + CW'(1);
        end else if (pop && count_reg != '0) begin
            ptr_next   = ptr_reg - PW'(1);
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            ptr_reg   <= '0;
            count_reg <= '0;
        end else begin
            ptr_reg   <= ptr_next;
            count_reg <= count_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge CLK) begin
                if (RES)
                    entry_reg[gi] <= '0;
                else if (push && ptr_reg == PW'(gi))
                    entry_reg[gi] <= push_data;
            end
        end
    endgenerate

    // The pointer addresses the next free slot, so the top lives one below it.
    assign top_data = entry_reg[ptr_reg - PW'(1)];
    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CW'(DEPTH));

endmodule

// File: rtl/pc_ctrl.sv
// RV32 fetch program counter: next-PC selection, trap entry/return with EPC,
// call/return through the RAS and rejection of misaligned or unmatched redirects.
module pc_ctrl
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR_DEFAULT),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(PC_TRAP_VECTOR_DEFAULT),
    parameter int              RAS_DEPTH    = 4
) (
    input  logic CLK,
    input  logic RES,
    pc_if.slave  bus
);
    localparam logic [XLEN-1:0] INCR = XLEN'(PC_INCR);

    generate
        if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_reset_vector
            $error("pc_ctrl: RESET_VECTOR must be 4-byte aligned");
        end
        if (TRAP_VECTOR[1:0] != 2'b00) begin : g_bad_trap_vector
            $error("pc_ctrl: TRAP_VECTOR must be 4-byte aligned");
        end
        if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
            $error("pc_ctrl: RAS_DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] epc_reg, epc_next;
    logic            fault_reg, fault_next;
    logic            ras_push, ras_pop;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty, ras_full;
    logic [XLEN-1:0] pc_seq;
    logic            target_ok;

    assign pc_seq    = pc_reg + INCR;
    assign target_ok = pc_is_aligned(bus.D[1:0]);

    always_comb begin
        pc_next    = pc_reg;
        epc_next   = epc_reg;
        fault_next = 1'b0;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        if (bus.TRAP) begin
            epc_next = pc_reg;
            pc_next  = TRAP_VECTOR;
        end else if (bus.TRAP_RET) begin
            pc_next = epc_reg;
        end else if (bus.ENABLE) begin
            case (pc_mode_t'(bus.MODE))
                PC_SEQ:  pc_next = pc_seq;
                PC_JUMP: begin
                    if (target_ok) pc_next = bus.D;
                    else           fault_next = 1'b1;
                end
                PC_CALL: begin
                    if (target_ok) begin
                        pc_next  = bus.D;
                        ras_push = 1'b1;
                    end else begin
                        fault_next = 1'b1;
                    end
                end
                PC_RET: begin
                    if (!ras_empty) begin
                        pc_next = ras_top;
                        ras_pop = 1'b1;
                    end else begin
                        fault_next = 1'b1;
                    end
                end
                default: pc_next = pc_reg;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            pc_reg    <= RESET_VECTOR;
            epc_reg   <= '0;
            fault_reg <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            epc_reg   <= epc_next;
            fault_reg <= fault_next;
        end
    end

    // Return address is the instruction after the call, wrapping at 2^XLEN.
    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK       (CLK),
        .RES       (RES),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_seq),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign bus.PC_OUT    = pc_reg;
    assign bus.EPC_OUT   = epc_reg;
    assign bus.FAULT     = fault_reg;
    assign bus.RAS_EMPTY = ras_empty;
    assign bus.RAS_FULL  = ras_full;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: stimulus queues hand-computed expectations,
// a monitor pops and compares them one cycle after each issue.
module tb_pc_ctrl;
    import pc_pkg::*;

    logic CLK = 1'b0;
    logic RES = 1'b0;
    always #5 CLK = ~CLK;

    logic        enable, trap, tret;
    logic [1:0]  mode;
    logic [31:0] d;

    pc_if #(.XLEN(32)) bus0 ();
    pc_if #(.XLEN(32)) bus1 ();

    assign bus0.ENABLE = enable;
    assign bus0.MODE = mode;
    assign bus0.D = d;
    assign bus0.TRAP = trap;
    assign bus0.TRAP_RET = tret;
    assign bus1.ENABLE = enable;
    assign bus1.MODE = mode;
    assign bus1.D = d;
    assign bus1.TRAP = trap;
    assign bus1.TRAP_RET = tret;

    pc_ctrl #(.XLEN(32), .RESET_VECTOR(32'h1A00_0000), .TRAP_VECTOR(32'h1A00_0080), .RAS_DEPTH(4))
        dut0 (.CLK(CLK), .RES(RES), .bus(bus0));

    pc_ctrl #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFFC), .TRAP_VECTOR(32'h1A00_0080), .RAS_DEPTH(4))
        dut1 (.CLK(CLK), .RES(RES), .bus(bus1));

    typedef struct {
        string       name;
        bit          dsel;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        fault;
        logic        empty;
        logic        full;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input string field,
                         input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s actual=%08h required=%08h", name, field, act, req);
        end
    endtask

    // Monitor: every issued cycle produces one PC update to compare.
    initial begin
        exp_t e;
        logic [31:0] pc_a, epc_a;
        logic f_a, em_a, fu_a;
        forever begin
            @(posedge CLK);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.dsel) begin
                    pc_a = bus1.PC_OUT; epc_a = bus1.EPC_OUT;
                    f_a = bus1.FAULT; em_a = bus1.RAS_EMPTY; fu_a = bus1.RAS_FULL;
                end else begin
                    pc_a = bus0.PC_OUT; epc_a = bus0.EPC_OUT;
                    f_a = bus0.FAULT; em_a = bus0.RAS_EMPTY; fu_a = bus0.RAS_FULL;
                end
                check(e.name, "pc", pc_a, e.pc);
                check(e.name, "epc", epc_a, e.epc);
                check(e.name, "fault", {31'b0, f_a}, {31'b0, e.fault});
                check(e.name, "empty", {31'b0, em_a}, {31'b0, e.empty});
                check(e.name, "full", {31'b0, fu_a}, {31'b0, e.full});
                $display("txn %-10s dut%0d pc=%08h epc=%08h fault=%0b empty=%0b full=%0b",
                         e.name, e.dsel, pc_a, epc_a, f_a, em_a, fu_a);
            end
        end
    end

    task automatic step(input string name, input bit res, input bit en,
                        input logic [1:0] md, input logic [31:0] dv,
                        input bit tr, input bit trr, input bit dsel,
                        input logic [31:0] pc, input logic [31:0] epc,
                        input bit f, input bit em, input bit fu);
        exp_t e;
        @(negedge CLK);
        RES = res; enable = en; mode = md; d = dv; trap = tr; tret = trr;
        e.name = name; e.dsel = dsel; e.pc = pc; e.epc = epc;
        e.fault = f; e.empty = em; e.full = fu;
        sb.push_back(e);
    endtask

    initial begin
        RES = 1'b0; enable = 1'b0; mode = PC_SEQ; d = '0; trap = 1'b0; tret = 1'b0;

        //    name        res en mode     d              tr tr dsel pc            epc           f em fu
        step("reset",     1, 0, PC_SEQ,  32'h0,         0, 0, 0, 32'h1A00_0000, 32'h0,        0, 1, 0);
        step("seq1",      0, 1, PC_SEQ,  32'h0,         0, 0, 0, 32'h1A00_0004, 32'h0,        0, 1, 0);
        step("seq2",      0, 1, PC_SEQ,  32'h0,         0, 0, 0, 32'h1A00_0008, 32'h0,        0, 1, 0);
        step("seq3",      0, 1, PC_SEQ,  32'h0,         0, 0, 0, 32'h1A00_000C, 32'h0,        0, 1, 0);
        step("stall1",    0, 0, PC_SEQ,  32'h0,         0, 0, 0, 32'h1A00_000C, 32'h0,        0, 1, 0);
        step("stall2",    0, 0, PC_JUMP, 32'h1A00_0100, 0, 0, 0, 32'h1A00_000C, 32'h0,        0, 1, 0);
        step("jump",      0, 1, PC_JUMP, 32'h1A00_0100, 0, 0, 0, 32'h1A00_0100, 32'h0,        0, 1, 0);
        step("jump_mis",  0, 1, PC_JUMP, 32'h1A00_0102, 0, 0, 0, 32'h1A00_0100, 32'h0,        1, 1, 0);
        step("fault_clr", 0, 0, PC_SEQ,  32'h0,         0, 0, 0, 32'h1A00_0100, 32'h0,        0, 1, 0);
        step("jump10",    0, 1, PC_JUMP, 32'h1A00_0010, 0, 0, 0, 32'h1A00_0010, 32'h0,        0, 1, 0);
        step("call",      0, 1, PC_CALL, 32'h1A00_0200, 0, 0, 0, 32'h1A00_0200, 32'h0,        0, 0, 0);
        step("ret",       0, 1, PC_RET,  32'h0,         0, 0, 0, 32'h1A00_0014, 32'h0,        0, 1, 0);
        step("ret_uf",    0, 1, PC_RET,  32'h0,         0, 0, 0, 32'h1A00_0014, 32'h0,        1, 1, 0);
        step("call_mis",  0, 1, PC_CALL, 32'h1A00_0201, 0, 0, 0, 32'h1A00_0014, 32'h0,        1, 1, 0);
        step("idle",      0, 0, PC_SEQ,  32'h0,         0, 0, 0, 32'h1A00_0014, 32'h0,        0, 1, 0);
        // Five nested calls on a four-entry stack: A1=..18 gets overwritten.
        step("call1",     0, 1, PC_CALL, 32'h1A00_0400, 0, 0, 0, 32'h1A00_0400, 32'h0,        0, 0, 0);
        step("call2",     0, 1, PC_CALL, 32'h1A00_0500, 0, 0, 0, 32'h1A00_0500, 32'h0,        0, 0, 0);
        step("call3",     0, 1, PC_CALL, 32'h1A00_0600, 0, 0, 0, 32'h1A00_0600, 32'h0,        0, 0, 0);
        step("call4",     0, 1, PC_CALL, 32'h1A00_0700, 0, 0, 0, 32'h1A00_0700, 32'h0,        0, 0, 1);
        step("call5",     0, 1, PC_CALL, 32'h1A00_0800, 0, 0, 0, 32'h1A00_0800, 32'h0,        0, 0, 1);
        step("ret1",      0, 1, PC_RET,  32'h0,         0, 0, 0, 32'h1A00_0704, 32'h0,        0, 0, 0);
        step("ret2",      0, 1, PC_RET,  32'h0,         0, 0, 0, 32'h1A00_0604, 32'h0,        0, 0, 0);
        step("ret3",      0, 1, PC_RET,  32'h0,         0, 0, 0, 32'h1A00_0504, 32'h0,        0, 0, 0);
        step("ret4",      0, 1, PC_RET,  32'h0,         0, 0, 0, 32'h1A00_0404, 32'h0,        0, 1, 0);
        step("ret5",      0, 1, PC_RET,  32'h0,         0, 0, 0, 32'h1A00_0404, 32'h0,        1, 1, 0);
        step("jump20",    0, 1, PC_JUMP, 32'h1A00_0020, 0, 0, 0, 32'h1A00_0020, 32'h0,        0, 1, 0);
        step("trap",      0, 1, PC_JUMP, 32'h1A00_0300, 1, 0, 0, 32'h1A00_0080, 32'h1A00_0020, 0, 1, 0);
        step("trap_ret",  0, 0, PC_SEQ,  32'h0,         0, 1, 0, 32'h1A00_0020, 32'h1A00_0020, 0, 1, 0);
        step("seq24",     0, 1, PC_SEQ,  32'h0,         0, 0, 0, 32'h1A00_0024, 32'h1A00_0020, 0, 1, 0);
        step("trap_both", 0, 1, PC_SEQ,  32'h0,         1, 1, 0, 32'h1A00_0080, 32'h1A00_0024, 0, 1, 0);
        step("trap_ret2", 0, 0, PC_SEQ,  32'h0,         0, 1, 0, 32'h1A00_0024, 32'h1A00_0024, 0, 1, 0);
        // Wrap-around checks on the instance reset to FFFF_FFFC.
        step("w_reset",   1, 0, PC_SEQ,  32'h0,         0, 0, 1, 32'hFFFF_FFFC, 32'h0,        0, 1, 0);
        step("w_seq",     0, 1, PC_SEQ,  32'h0,         0, 0, 1, 32'h0000_0000, 32'h0,        0, 1, 0);
        step("w_reset2",  1, 1, PC_SEQ,  32'h0,         0, 0, 1, 32'hFFFF_FFFC, 32'h0,        0, 1, 0);
        step("w_call",    0, 1, PC_CALL, 32'h0000_0100, 0, 0, 1, 32'h0000_0100, 32'h0,        0, 0, 0);
        step("w_ret",     0, 1, PC_RET,  32'h0,         0, 0, 1, 32'h0000_0000, 32'h0,        0, 1, 0);
        step("w_call2",   0, 1, PC_CALL, 32'h0000_0200, 0, 0, 1, 32'h0000_0200, 32'h0,        0, 0, 0);
        step("rst_call",  1, 1, PC_CALL, 32'h0000_0300, 0, 0, 1, 32'hFFFF_FFFC, 32'h0,        0, 1, 0);
        step("rst_ret",   0, 1, PC_RET,  32'h0,         0, 0, 1, 32'hFFFF_FFFC, 32'h0,        1, 1, 0);

        @(negedge CLK);
        RES = 1'b0; enable = 1'b0; trap = 1'b0; tret = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge CLK);
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
